ram_copy_engine: RTL
====================

# ram_copy_engine

Bus initiator that drives the single-port RAM interface (data in, load, address, combinational data out) to copy or fill blocks of words without CPU involvement. It sits between the control logic and a RAM16K instance and owns the RAM port while busy. Each copy takes a read cycle then a write cycle per word; each fill takes one write cycle per word. A start/busy/done handshake controls it.

## Interface
Parameters:
- AW, 14, RAM address width (RAM16K).
- DW, 16, data word width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- mode  in  1  0 = copy, 1 = fill; latched on accepted start.
- src  in  AW  copy source base address; latched on start.
- dst  in  AW  destination base address; latched on start.
- len  in  AW+1  word count, 0..2^AW; latched on start.
- pattern  in  DW  fill value; latched on start.
- busy  out  1  high from the cycle after an accepted start through the last RAM access.
- done  out  1  one-cycle pulse after the transfer completes.
- ram_in  out  DW  write data to RAM.
- ram_load  out  1  RAM write enable.
- ram_address  out  AW  RAM address.
- ram_out  in  DW  RAM read data, combinational from ram_address.

## Operation
- States: IDLE, RD, WR, FIN.
- IDLE: if start=1, latch mode/src/dst/len/pattern and clear index i.
  - len=0 goes to FIN.
  - mode=copy goes to RD.
  - mode=fill goes to WR.
- RD: ram_address = src+i, ram_load=0. At the clock edge, capture ram_out into the data buffer, then go to WR.
- WR: ram_address = dst+i, ram_in = buffer (copy) or pattern (fill), ram_load=1. At the edge, the RAM writes and i increments.
  - If i+1 = len, go to FIN.
  - Otherwise go to RD (copy) or stay in WR (fill).
- FIN: done=1, busy=0, ram_load=0; next state IDLE.
- Address arithmetic is modulo 2^AW: src+i and dst+i wrap from 2^AW-1 to 0 silently.
- Copy is always ascending. For overlapping ranges with dst>src, the overwritten source words propagate; this is the defined behaviour, not an error.
- start while busy or in FIN is ignored; inputs are not re-latched.
- Outside RD/WR: ram_load=0 and ram_address holds its last value; ram_in holds its last value.
- ram_load is asserted only in WR.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, ram_load=0, ram_address=0, ram_in=0, i=0, buffer=0.
- Reset mid-transfer aborts immediately. ram_load drops without waiting for a clock, and words already written stay written.
- Outputs are driven from registers only; there is no combinational path from start, src, dst, or len to any output.
- Accepted start at edge t:
  - copy: busy rises after t, RD occupies cycle t+1 and WR cycle t+2. Busy lasts 2·len cycles, then done pulses for one cycle.
  - fill: busy lasts len cycles, then done pulses.
  - len=0: busy never rises; done pulses in cycle t+1; no RAM write occurs.
- Back-to-back: start asserted during the done cycle is ignored. The earliest accepted start is in the following IDLE cycle.
- Maximum len = 2^AW: a full copy takes 2^(AW+1) busy cycles. The counter must not overflow; len is AW+1 bits.

## Structure
- Shared package/header `ram_dma_defs`: state encodings (IDLE, RD, WR, FIN, 2-bit), mode constants MODE_COPY=0 and MODE_FILL=1, default AW/DW.
- No sub-module is required; the FSM, index counter and data buffer live in one module.
- The bench instantiates ram_copy_engine with a RAM16K model connected to the ram_* ports.

## Test plan
- Preload RAM[0x0010..0x0013] = 0xA000..0xA003; copy src=0x0010, dst=0x0100, len=4 -> RAM[0x0100..0x0103] = 0xA000..0xA003, busy for 8 cycles, one done pulse, source unchanged.
- Fill dst=0x0200, len=3, pattern=0x5A5A -> RAM[0x0200..0x0202] = 0x5A5A, busy for 3 cycles, ram_load high exactly 3 cycles, RAM[0x0203] untouched.
- Copy src=0x3FFE, dst=0x0000, len=4 with RAM[0x3FFE]=1, [0x3FFF]=2, [0x0000]=3, [0x0001]=4 -> reads wrap to 0x0000. Forward overlap gives RAM[0x0000..0x0003] = 1,2,1,2.
- len=0 start -> done in the next cycle, busy stays 0, ram_load never asserts. A start pulsed mid-transfer (len=8) is ignored and the final contents match a single transfer.
- Deassert rst_n asynchronously during WR of word 2 of a len=5 fill -> ram_load=0 and busy=0 with no clock. Words 0-1 are written, words 2-4 are not, and the state returns to IDLE.

Source files
------------

// File: rtl/ram_dma_defs.sv
// Shared definitions for the RAM copy/fill engine: FSM encodings, mode values
// and default bus widths.
package ram_dma_defs;

  localparam int DEF_AW = 14;
  localparam int DEF_DW = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/ram_copy_engine.sv
// Bus initiator that copies or fills blocks of RAM words through a single-port
// RAM interface, with a start/busy/done handshake.
module ram_copy_engine
  import ram_dma_defs::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW:0]   len,
  input  logic [DW-1:0] pattern,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] ram_in,
  output logic          ram_load,
  output logic [AW-1:0] ram_address,
  input  logic [DW-1:0] ram_out
);

  logic [1:0]    state_reg, state_next;
  logic          mode_reg, mode_next;
  logic [AW-1:0] src_reg, src_next;
  logic [AW-1:0] dst_reg, dst_next;
  logic [AW:0]   len_reg, len_next;
  logic [AW:0]   idx_reg, idx_next;
  logic [AW-1:0] addr_reg, addr_next;
  // data_reg is both the copy buffer and the write-data register; in fill mode
  // it is loaded with the pattern once and held.
  logic [DW-1:0] data_reg, data_next;

  logic [AW:0]   idx_inc;
  logic          last_word;

  assign idx_inc   = idx_reg + {{AW{1'b0}}, 1'b1};
  assign last_word = (idx_inc == len_reg);

  always_comb begin
    state_next = state_reg;
    mode_next  = mode_reg;
    src_next   = src_reg;
    dst_next   = dst_reg;
    len_next   = len_reg;
    idx_next   = idx_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          mode_next = mode;
          src_next  = src;
          dst_next  = dst;
          len_next  = len;
          idx_next  = '0;
          if (len == '0) begin
            state_next = ST_FIN;
          end else if (mode == MODE_COPY) begin
            state_next = ST_RD;
            addr_next  = src;
          end else begin
            state_next = ST_WR;
            addr_next  = dst;
            data_next  = pattern;
          end
        end
      end
      ST_RD: begin
        data_next  = ram_out;
        addr_next  = dst_reg + idx_reg[AW-1:0];
        state_next = ST_WR;
      end
      ST_WR: begin
        idx_next = idx_inc;
        if (last_word) begin
          state_next = ST_FIN;
        end else if (mode_reg == MODE_COPY) begin
          state_next = ST_RD;
          addr_next  = src_reg + idx_inc[AW-1:0];
        end else begin
          addr_next  = dst_reg + idx_inc[AW-1:0];
        end
      end
      ST_FIN: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      mode_reg  <= MODE_COPY;
      src_reg   <= '0;
      dst_reg   <= '0;
      len_reg   <= '0;
      idx_reg   <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      mode_reg  <= mode_next;
      src_reg   <= src_next;
      dst_reg   <= dst_next;
      len_reg   <= len_next;
      idx_reg   <= idx_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
    end
  end

  // Outputs decode only registered state, so reset drops them without a clock.
  assign busy        = (state_reg == ST_RD) || (state_reg == ST_WR);
  assign done        = (state_reg == ST_FIN);
  assign ram_load    = (state_reg == ST_WR);
  assign ram_address = addr_reg;
  assign ram_in      = data_reg;

endmodule
